// File: rtl/csr_spmv_engine.sv
// csr_spmv_engine: CSR sparse matrix x dense vector engine; optional output saturation with SPMV_SAT_EN
module csr_spmv_engine #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int ROW_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  n_rows,
  output logic              ptr_en,
  output logic [ADDR_W-1:0] ptr_addr0,
  output logic [ADDR_W-1:0] ptr_addr1,
  input  logic [ADDR_W-1:0] ptr_dout0,
  input  logic [ADDR_W-1:0] ptr_dout1,
  output logic              nz_en,
  output logic [ADDR_W-1:0] nz_addr0,
  output logic [ADDR_W-1:0] nz_addr1,
  input  logic [DATA_W-1:0] nz_dout0,
  input  logic [DATA_W-1:0] nz_dout1,
  output logic              vec_en,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [DATA_W-1:0] vec_dout,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [ROW_W-1:0]  y_row,
  output logic [DATA_W-1:0] y_data,
  output logic              busy,
  output logic              done
`ifdef SPMV_SAT_EN
  ,
  output logic              sat
`endif
);
  typedef enum logic [2:0] {IDLE, PTR_RD, PTR_CAP, NZ_RD, X_RD, MAC, EMIT, FIN} state_t;
  state_t r_state;
  logic [ROW_W-1:0] r_row, r_nrows;
  logic [ADDR_W-1:0] r_k, r_end;
  logic signed [DATA_W-1:0] r_val;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_ydata;
  logic w_sat;
  logic [ROW_W-1:0] w_row_nx;
  logic w_unused;
  assign w_prod = $signed(r_val) * $signed(vec_dout);
  assign w_row_nx = r_row + ROW_W'(1);
  assign w_unused = ^{nz_dout1[DATA_W-1:ADDR_W], w_prod[2*DATA_W-1:ACC_W]};
  // Read strobes come straight from the state; addresses are forced to 0 when idle
  assign ptr_en = r_state == PTR_RD;
  assign ptr_addr0 = ptr_en ? ADDR_W'(r_row) : '0;
  assign ptr_addr1 = ptr_en ? ADDR_W'(r_row) + ADDR_W'(1) : '0;
  assign nz_en = r_state == NZ_RD;
  assign nz_addr0 = nz_en ? {r_k[ADDR_W-2:0], 1'b0} : '0;
  assign nz_addr1 = nz_en ? {r_k[ADDR_W-2:0], 1'b1} : '0;
  assign vec_en = r_state == X_RD;
  assign vec_addr = vec_en ? nz_dout1[ADDR_W-1:0] : '0;
`ifdef SPMV_SAT_EN
  logic w_pos_ovf, w_neg_ovf;
  assign w_pos_ovf = !r_acc[ACC_W-1] && (|r_acc[ACC_W-2:DATA_W-1]);
  assign w_neg_ovf = r_acc[ACC_W-1] && !(&r_acc[ACC_W-2:DATA_W-1]);
  assign w_sat = w_pos_ovf || w_neg_ovf;
  assign w_ydata = w_pos_ovf ? {1'b0, {(DATA_W-1){1'b1}}} :
                   w_neg_ovf ? {1'b1, {(DATA_W-1){1'b0}}} : r_acc[DATA_W-1:0];
`else
  assign w_sat = 1'b0;
  assign w_ydata = r_acc[DATA_W-1:0];
`endif
  // Row walk FSM; result handshake and status flags are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_row <= '0;
      r_nrows <= '0;
      r_k <= '0;
      r_end <= '0;
      r_val <= '0;
      r_acc <= '0;
      y_valid <= 1'b0;
      y_row <= '0;
      y_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef SPMV_SAT_EN
      sat <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, FIN: begin
          if (r_state == FIN) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
          if (start) begin
            r_nrows <= n_rows;
            r_row <= '0;
            done <= 1'b0;
            busy <= 1'b1;
            r_state <= (n_rows == '0) ? FIN : PTR_RD;
          end
        end
        PTR_RD: r_state <= PTR_CAP;
        PTR_CAP: begin
          r_k <= ptr_dout0;
          r_end <= ptr_dout1;
          r_acc <= '0;
          r_state <= (ptr_dout0 >= ptr_dout1) ? EMIT : NZ_RD;
        end
        NZ_RD: r_state <= X_RD;
        X_RD: begin
          r_val <= nz_dout0;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= r_acc + w_prod[ACC_W-1:0];
          r_k <= r_k + ADDR_W'(1);
          r_state <= (r_k + ADDR_W'(1) < r_end) ? NZ_RD : EMIT;
        end
        EMIT: begin
          if (y_valid && y_ready) begin
            y_valid <= 1'b0;
`ifdef SPMV_SAT_EN
            sat <= 1'b0;
`endif
            r_row <= w_row_nx;
            r_state <= (w_row_nx == r_nrows) ? FIN : PTR_RD;
          end else begin
            y_valid <= 1'b1;
            y_row <= r_row;
            y_data <= w_ydata;
`ifdef SPMV_SAT_EN
            sat <= w_sat;
`endif
          end
        end
      endcase
    end
  end
endmodule
